pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC SHALL be 32 bits, default 32'h0000_0000; it is the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 pcNext  input  32  SHALL be the next PC chosen by the PC selector (PC+4 or branch/jump target).
REQ-005 redirect  input  1  SHALL mark a taken branch/jump; it is the same signal as the selector's pcSrc.
REQ-006 pcPlusFour  output  32  SHALL equal pc + 4 (modulo 2^32), combinational from the PC register, for the PC selector.
REQ-007 imemReq  output  1  SHALL be the instruction-memory read request.
REQ-008 imemAddr  output  32  SHALL be the read address, equal to the PC register.
REQ-009 imemGnt  input  1  SHALL indicate the memory accepted the request this cycle.
REQ-010 imemRvalid  input  1  SHALL indicate imemRdata is valid this cycle.
REQ-011 imemRdata  input  32  SHALL be the returned instruction word.
REQ-012 ifValid  output  1  SHALL indicate ifPc and ifInstr hold a fetched instruction for decode.
REQ-013 ifPc  output  32  SHALL be the address of the held instruction.
REQ-014 ifInstr  output  32  SHALL be the held instruction word.
REQ-015 idReady  input  1  SHALL indicate decode accepts the held instruction this cycle.
REQ-016 fetchErr  output  1  SHALL be a sticky misaligned-PC error flag.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, HOLD and ERR.
REQ-018 IDLE SHALL drive imemReq=0 and SHALL go to REQ on the next edge.
REQ-019 REQ SHALL drive imemReq=1. imemGnt=1 SHALL move the state to WAIT.
REQ-020 imemAddr SHALL stay stable while imemReq=1 and imemGnt=0, except when redirect is asserted (see REQ-025).
REQ-021 WAIT SHALL drive imemReq=0. On imemRvalid=1, ifInstr SHALL take imemRdata, ifPc SHALL take the PC, and the state SHALL go to HOLD. imemRvalid arriving in the grant cycle itself SHALL be ignored.
REQ-022 HOLD SHALL drive ifValid=1 with ifPc and ifInstr stable until handoff (ifValid=1 and idReady=1).
REQ-023 On handoff, the PC SHALL load pcNext, ifValid SHALL fall the next cycle, and the state SHALL go to REQ.
REQ-024 Latency: ifValid SHALL rise exactly one cycle after the accepted imemRvalid. Best-case throughput is one instruction per 3 cycles.
REQ-025 redirect=1 in REQ without imemGnt SHALL load the PC from pcNext and stay in REQ.
REQ-026 redirect=1 in REQ together with imemGnt SHALL load the PC from pcNext, enter WAIT with a drop flag set, discard the returning word, then go to REQ.
REQ-027 redirect=1 in WAIT SHALL load the PC from pcNext and set the drop flag. The pending response SHALL be discarded (ifValid stays 0), then the state SHALL go to REQ. redirect together with imemRvalid SHALL also discard that word.
REQ-028 redirect=1 in HOLD, with or without idReady, SHALL load the PC from pcNext, drop ifValid the next cycle, and go to REQ. If idReady=1 in the same cycle, the held instruction SHALL count as handed off.
REQ-029 Any PC load where pcNext[1:0]!=2'b00 SHALL set fetchErr and enter ERR.
REQ-030 ERR SHALL hold imemReq=0 and ifValid=0 and SHALL ignore all inputs until reset.
REQ-031 A misaligned load SHALL be reported even if it coincides with a pending drop.
REQ-032 The PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error; pcPlusFour SHALL then be 32'h0000_0000.

Reset
REQ-033 While rst_n=0, the block SHALL hold: state=IDLE, PC=RESET_PC, imemReq=0, ifValid=0, ifPc=0, ifInstr=0, fetchErr=0, drop flag=0.
REQ-034 Reset asserted mid-transaction SHALL abandon it. A response arriving after reset release and before the first grant SHALL be ignored.

Verification
REQ-035 Reset release with RESET_PC=0, imemGnt=1 in the first REQ cycle, rvalid 2 cycles later with data 32'h0000_0013, idReady=1, pcNext=pcPlusFour -> ifValid=1 with ifPc=0 and ifInstr=32'h13; the next request has imemAddr=32'h4.
REQ-036 idReady=0 held for 5 cycles in HOLD -> ifValid, ifPc and ifInstr stay constant and no new imemReq is issued; the first cycle with idReady=1 completes the handoff.
REQ-037 redirect=1 with pcNext=32'h100 in WAIT, then rvalid with 32'hDEAD_BEEF -> ifValid never asserts for that word; the next imemAddr=32'h100.
REQ-038 redirect=1 and idReady=1 in the same HOLD cycle, pcNext=32'h200 -> exactly one handoff occurs; the next imemAddr=32'h200.
REQ-039 Handoff with pcNext=32'h102 -> fetchErr=1 and the state stays in ERR with imemReq=0 indefinitely; rst_n low clears it and fetch resumes at RESET_PC.
REQ-040 PC=32'hFFFF_FFFC, handoff with pcNext=pcPlusFour -> pcPlusFour=0 and the next imemAddr=32'h0 with fetchErr=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one imem read at a time,
// and holds the returned word for decode. Redirects cancel any in-flight fetch.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcNext,
  input  logic        redirect,
  output logic [31:0] pcPlusFour,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic        ifValid,
  output logic [31:0] ifPc,
  output logic [31:0] ifInstr,
  input  logic        idReady,
  output logic        fetchErr
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} stateT;

  stateT       state;
  stateT       stateNext;
  logic [31:0] pc;
  logic [31:0] pcD;
  logic        drop;
  logic        dropD;
  logic        loadPc;
  logic        capture;
  logic        misaligned;

  assign imemAddr   = pc;
  assign pcPlusFour = pc + 32'd4;
  assign misaligned = (pcNext[1:0] != 2'b00);

  always_comb begin
    stateNext = state;
    pcD       = pc;
    dropD     = drop;
    loadPc    = 1'b0;
    capture   = 1'b0;
    imemReq   = 1'b0;
    ifValid   = 1'b0;
    unique case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        imemReq = 1'b1;
        loadPc  = redirect;
        if (imemGnt) begin
          stateNext = WAIT;
          dropD     = redirect;
        end
      end
      WAIT: begin
        if (redirect) begin
          loadPc = 1'b1;
          dropD  = 1'b1;
        end
        // A word that returns under a redirect (now or earlier) is stale.
        if (imemRvalid) begin
          dropD     = 1'b0;
          stateNext = REQ;
          if (!drop && !redirect) begin
            capture   = 1'b1;
            stateNext = HOLD;
          end
        end
      end
      HOLD: begin
        ifValid = 1'b1;
        if (redirect || idReady) begin
          loadPc    = 1'b1;
          stateNext = REQ;
        end
      end
      ERR: stateNext = ERR;
      default: stateNext = IDLE;
    endcase
    if (loadPc) begin
      pcD = pcNext;
      if (misaligned) stateNext = ERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      fetchErr <= 1'b0;
      ifPc     <= 32'h0;
      ifInstr  <= 32'h0;
    end else begin
      state <= stateNext;
      pc    <= pcD;
      drop  <= dropD;
      if (loadPc && misaligned) fetchErr <= 1'b1;
      if (capture) begin
        ifPc    <= pc;
        ifInstr <= imemRdata;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios, then a randomized run against
// an address-sequence reference model with a queue-based scoreboard.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcNext;
  logic        redirect;
  logic [31:0] pcPlusFour;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        ifValid;
  logic [31:0] ifPc;
  logic [31:0] ifInstr;
  logic        idReady;
  logic        fetchErr;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pcNext(pcNext), .redirect(redirect),
    .pcPlusFour(pcPlusFour), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemGnt(imemGnt), .imemRvalid(imemRvalid), .imemRdata(imemRdata),
    .ifValid(ifValid), .ifPc(ifPc), .ifInstr(ifInstr), .idReady(idReady),
    .fetchErr(fetchErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetchT;

  fetchT expQ[$];
  fetchT cur;
  int    passCnt  = 0;
  int    totalCnt = 0;
  logic  sbOn     = 1'b0;
  logic  shown    = 1'b0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h1357_9BDF ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Scoreboard monitor: pops an expectation each time a new instruction is presented.
  always @(negedge clk) begin
    if (sbOn) begin
      if (ifValid) begin
        if (!shown) begin
          shown = 1'b1;
          totalCnt++;
          if (expQ.size() == 0) $display("FAIL sb_unexpected: presented pc %h with no expectation", ifPc);
          else begin
            passCnt++;
            cur = expQ.pop_front();
          end
        end
        chk("sb_pc", ifPc, cur.pc);
        chk("sb_instr", ifInstr, cur.instr);
      end else begin
        shown = 1'b0;
      end
      chk("sb_pcplus4", pcPlusFour, imemAddr + 32'd4);
      chk1("sb_noerr", fetchErr, 1'b0);
    end
  end

  task automatic clearInputs();
    pcNext = 32'h0; redirect = 1'b0; imemGnt = 1'b0; imemRvalid = 1'b0;
    imemRdata = 32'h0; idReady = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 1'b0;
    @(negedge clk);
    chk1("rst_req", imemReq, 1'b0);
    chk1("rst_valid", ifValid, 1'b0);
    chk("rst_ifpc", ifPc, 32'h0);
    chk("rst_ifinstr", ifInstr, 32'h0);
    chk1("rst_err", fetchErr, 1'b0);
    chk("rst_addr", imemAddr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Starts in REQ at a negedge; a junk rvalid in the grant cycle must be ignored.
  task automatic fetchOne(input logic [31:0] addr, input logic [31:0] word, input int rvDelay,
                          input int holdCycles, input logic [31:0] nxt, input logic rd);
    chk1("req_high", imemReq, 1'b1);
    chk("req_addr", imemAddr, addr);
    imemGnt = 1'b1; imemRvalid = 1'b1; imemRdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imemGnt = 1'b0; imemRvalid = 1'b0;
    for (int i = 1; i < rvDelay; i++) begin
      chk1("wait_noreq", imemReq, 1'b0);
      @(negedge clk);
    end
    chk1("wait_novalid", ifValid, 1'b0);
    imemRvalid = 1'b1; imemRdata = word;
    @(negedge clk);
    imemRvalid = 1'b0; imemRdata = 32'h0;
    chk1("hold_valid", ifValid, 1'b1);
    chk("hold_pc", ifPc, addr);
    chk("hold_instr", ifInstr, word);
    for (int i = 0; i < holdCycles; i++) begin
      idReady = 1'b0;
      @(negedge clk);
      chk1("stall_valid", ifValid, 1'b1);
      chk("stall_pc", ifPc, addr);
      chk("stall_instr", ifInstr, word);
      chk1("stall_noreq", imemReq, 1'b0);
    end
    idReady = 1'b1; redirect = rd; pcNext = nxt;
    @(negedge clk);
    idReady = 1'b0; redirect = 1'b0;
    chk1("handoff_valid_low", ifValid, 1'b0);
  endtask

  logic [31:0] modelPc;
  int          pend;
  logic [31:0] pendAddr;
  int          idleCyc;

  initial begin
    clearInputs();
    rst_n = 1'b1;
    @(negedge clk);
    doReset();

    // Response before the first grant is ignored.
    imemRvalid = 1'b1; imemRdata = 32'hFFFF_0000;
    @(negedge clk);
    imemRvalid = 1'b0;
    chk1("early_rvalid_novalid", ifValid, 1'b0);
    chk1("early_rvalid_req", imemReq, 1'b1);

    fetchOne(32'h0, 32'h0000_0013, 2, 0, 32'h4, 1'b0);
    chk("next_addr_4", imemAddr, 32'h4);
    fetchOne(32'h4, 32'h00A0_0093, 1, 5, 32'h8, 1'b0);
    chk("next_addr_8", imemAddr, 32'h8);

    // Redirect while waiting drops the returning word.
    imemGnt = 1'b1;
    @(negedge clk);
    imemGnt = 1'b0; redirect = 1'b1; pcNext = 32'h100;
    @(negedge clk);
    redirect = 1'b0; imemRvalid = 1'b1; imemRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imemRvalid = 1'b0;
    chk1("drop_wait_novalid", ifValid, 1'b0);
    chk1("drop_wait_req", imemReq, 1'b1);
    chk("drop_wait_addr", imemAddr, 32'h100);
    @(negedge clk);
    chk1("drop_wait_novalid2", ifValid, 1'b0);

    fetchOne(32'h100, 32'h1111_2222, 1, 1, 32'h200, 1'b1);
    chk("hold_redirect_addr", imemAddr, 32'h200);

    // Address stable without grant; redirect in REQ retargets it.
    @(negedge clk);
    chk("req_stable", imemAddr, 32'h200);
    redirect = 1'b1; pcNext = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    chk1("req_redirect_req", imemReq, 1'b1);
    chk("req_redirect_addr", imemAddr, 32'h300);

    // Redirect together with grant: word dropped, refetch at new target.
    imemGnt = 1'b1; redirect = 1'b1; pcNext = 32'h400;
    @(negedge clk);
    imemGnt = 1'b0; redirect = 1'b0;
    chk1("gnt_redirect_wait", imemReq, 1'b0);
    imemRvalid = 1'b1; imemRdata = 32'h3333_4444;
    @(negedge clk);
    imemRvalid = 1'b0;
    chk1("gnt_redirect_novalid", ifValid, 1'b0);
    chk("gnt_redirect_addr", imemAddr, 32'h400);

    // PC wrap.
    redirect = 1'b1; pcNext = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    chk("wrap_pcplus4", pcPlusFour, 32'h0);
    fetchOne(32'hFFFF_FFFC, 32'h5555_6666, 1, 0, 32'h0, 1'b0);
    chk("wrap_addr", imemAddr, 32'h0);
    chk1("wrap_noerr", fetchErr, 1'b0);

    // Misaligned handoff target locks into ERR.
    fetchOne(32'h0, 32'h7777_8888, 1, 0, 32'h102, 1'b0);
    chk1("err_flag", fetchErr, 1'b1);
    for (int i = 0; i < 5; i++) begin
      imemGnt = 1'b1; imemRvalid = 1'b1; idReady = 1'b1; redirect = 1'b1; pcNext = 32'h40;
      @(negedge clk);
      chk1("err_noreq", imemReq, 1'b0);
      chk1("err_novalid", ifValid, 1'b0);
      chk1("err_sticky", fetchErr, 1'b1);
    end
    doReset();
    chk("err_resume_addr", imemAddr, 32'h0);
    chk1("err_resume_req", imemReq, 1'b1);

    // Misaligned redirect while a drop is pending still reports.
    imemGnt = 1'b1; redirect = 1'b1; pcNext = 32'h40;
    @(negedge clk);
    imemGnt = 1'b0; pcNext = 32'h46;
    @(negedge clk);
    redirect = 1'b0;
    chk1("drop_err_flag", fetchErr, 1'b1);
    chk1("drop_err_noreq", imemReq, 1'b0);
    doReset();

    // Randomized run against the address-sequence model.
    modelPc = 32'h0;
    expQ.delete();
    expQ.push_back({modelPc, memWord(modelPc)});
    pend = 0; pendAddr = 32'h0; idleCyc = 0;
    shown = 1'b0;
    sbOn = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      #1;
      imemGnt = 1'b0; imemRvalid = 1'b0; imemRdata = 32'h0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          imemRvalid = 1'b1;
          imemRdata  = memWord(pendAddr);
        end
      end else if (imemReq && $urandom_range(0, 2) != 0) begin
        imemGnt  = 1'b1;
        pendAddr = imemAddr;
        pend     = $urandom_range(1, 3);
      end
      idReady  = 1'($urandom_range(0, 1));
      redirect = 1'b0;
      pcNext   = modelPc + 32'd4;
      if ($urandom_range(0, 9) == 0) begin
        redirect = 1'b1;
        if ($urandom_range(0, 3) == 0) pcNext = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
        else pcNext = $urandom() & 32'hFFFF_FFFC;
      end
      if (redirect || (ifValid && idReady)) begin
        modelPc = pcNext;
        expQ.delete();
        expQ.push_back({modelPc, memWord(modelPc)});
      end
      if (ifValid) idleCyc = 0;
      else idleCyc++;
      if (idleCyc > 200) begin
        totalCnt++;
        $display("FAIL progress_timeout: no instruction for %0d cycles, expected one", idleCyc);
        break;
      end
    end
    @(negedge clk);
    sbOn = 1'b0;

    // Reset in the middle of activity abandons it.
    clearInputs();
    rst_n = 1'b0;
    #2;
    chk1("midrst_req", imemReq, 1'b0);
    chk1("midrst_valid", ifValid, 1'b0);
    chk("midrst_addr", imemAddr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("midrst_resume_req", imemReq, 1'b1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
